// File: rtl/cv32e40px_mw_fifo.sv
// Multi-wide FIFO for the prefetch/aligner path: up to PUSH_W in, POP_W out per cycle.
// Optional watermarks built only with `define CV32E40PX_MW_FIFO_WATERMARK_EN.
module cv32e40px_mw_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PUSH_W     = 2,
  parameter int unsigned POP_W      = 2,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 1,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned PSH_W     = $clog2(PUSH_W + 1),
  localparam int unsigned POP_CW    = $clog2(POP_W + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              flush_but_first_i,
  input  logic [PSH_W-1:0]                  push_cnt_i,
  input  logic [PUSH_W-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [POP_CW-1:0]                 pop_cnt_i,
  output logic [POP_W-1:0][DATA_WIDTH-1:0]  data_o,
  output logic [POP_W-1:0]                  valid_o,
  output logic [CNT_W-1:0]                  cnt_o,
  output logic [CNT_W-1:0]                  free_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              almost_full_o,
  output logic                              almost_empty_o,
  output logic                              overflow_o,
  output logic                              underflow_o
);

  localparam logic [ADDR_W:0]  DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [ADDR_W-1:0] rptr_q, wptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  free;
  logic [CNT_W-1:0]  acc_push, acc_pop;
  logic              push_ok, pop_ok;
  logic              any_flush;
  logic              flush_all;

  // Operands never exceed DEPTH, so one conditional subtract wraps exactly.
  function automatic logic [ADDR_W-1:0] wrap_add(
    input logic [ADDR_W-1:0] p,
    input logic [ADDR_W:0]   n
  );
    logic [ADDR_W:0] s;
    s = {1'b0, p} + n;
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[ADDR_W-1:0];
  endfunction

  assign free      = DEPTH_C - cnt_q;
  assign any_flush = flush_i | flush_but_first_i;
  assign flush_all = flush_i | (flush_but_first_i & (cnt_q == '0));

  assign push_ok = (push_cnt_i <= PSH_W'(PUSH_W)) &&
                   (CNT_W'(push_cnt_i) <= free);
  assign pop_ok  = (CNT_W'(pop_cnt_i) <= cnt_q);

  assign acc_push = push_ok ? CNT_W'(push_cnt_i) : '0;
  assign acc_pop  = pop_ok  ? CNT_W'(pop_cnt_i)  : '0;

  assign overflow_o  = ~any_flush & ~push_ok;
  assign underflow_o = ~any_flush & ~pop_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_all) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_but_first_i) begin
      wptr_q <= wrap_add(rptr_q, (ADDR_W+1)'(1));
      cnt_q  <= CNT_W'(1);
    end else begin
      if (push_ok) begin
        for (int i = 0; i < PUSH_W; i++) begin
          if (PSH_W'(i) < push_cnt_i)
            mem_q[wrap_add(wptr_q, (ADDR_W+1)'(i))] <= data_i[i];
        end
        wptr_q <= wrap_add(wptr_q, (ADDR_W+1)'(push_cnt_i));
      end
      if (pop_ok)
        rptr_q <= wrap_add(rptr_q, (ADDR_W+1)'(pop_cnt_i));
      cnt_q <= cnt_q + acc_push - acc_pop;
    end
  end

  for (genvar k = 0; k < POP_W; k++) begin : g_rd
    assign data_o[k]  = mem_q[wrap_add(rptr_q, (ADDR_W+1)'(k))];
    assign valid_o[k] = (CNT_W'(k) < cnt_q);
  end

  assign cnt_o   = cnt_q;
  assign free_o  = free;
  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);

`ifdef CV32E40PX_MW_FIFO_WATERMARK_EN
  assign almost_full_o  = (cnt_q >= CNT_W'(AFULL_TH));
  assign almost_empty_o = (cnt_q <= CNT_W'(AEMPTY_TH));
`else
  assign almost_full_o  = 1'b0;
  assign almost_empty_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40px_mw_fifo.sv
// Bench for cv32e40px_mw_fifo: directed table, corner sequences and a
// randomized run against a queue-based reference.
module tb_cv32e40px_mw_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush, fbf;
  logic [1:0]       push_cnt;
  logic [1:0][31:0] data_i;
  logic [1:0]       pop_cnt;
  logic [1:0][31:0] data_o;
  logic [1:0]       valid_o;
  logic [2:0]       cnt_o, free_o;
  logic full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o;

  cv32e40px_mw_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_W(2), .POP_W(2),
    .AFULL_TH(4), .AEMPTY_TH(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .flush_but_first_i(fbf), .push_cnt_i(push_cnt),
    .data_i(data_i), .pop_cnt_i(pop_cnt), .data_o(data_o),
    .valid_o(valid_o), .cnt_o(cnt_o), .free_o(free_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(afull_o), .almost_empty_o(aempty_o),
    .overflow_o(ovf_o), .underflow_o(udf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned q[$];

  typedef struct {
    bit fl; bit fb; int pc; int unsigned d0; int unsigned d1; int pp;
    int cnt; bit ovf; bit udf; int unsigned head;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_state();
    int n;
    logic [1:0] ev;
    n = q.size();
    ev = (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
    chk("cnt", cnt_o, n);
    chk("free", free_o, DEPTH - n);
    chk("full", full_o, n == DEPTH);
    chk("empty", empty_o, n == 0);
    chk("valid", valid_o, ev);
    for (int k = 0; k < 2; k++)
      if (k < n) chk($sformatf("data%0d", k), data_o[k], q[k]);
`ifdef CV32E40PX_MW_FIFO_WATERMARK_EN
    chk("afull", afull_o, n >= 4);
    chk("aempty", aempty_o, n <= 1);
`else
    chk("afull", afull_o, 0);
    chk("aempty", aempty_o, 0);
`endif
  endtask

  // One clock: drive, check flags against the reference, advance both.
  task automatic step(input bit fl, input bit fb, input int pc,
                      input int unsigned d0, input int unsigned d1,
                      input int pp, output bit ovf_s, output bit udf_s);
    bit pok, qok;
    int unsigned h;
    @(negedge clk);
    flush = fl; fbf = fb;
    push_cnt = 2'(pc); pop_cnt = 2'(pp);
    data_i[0] = d0; data_i[1] = d1;
    pok = (pc <= 2) && (pc <= DEPTH - q.size());
    qok = (pp <= q.size());
    #1;
    ovf_s = ovf_o; udf_s = udf_o;
    chk("overflow", ovf_o, !(fl || fb) && !pok);
    chk("underflow", udf_o, !(fl || fb) && !qok);
    @(posedge clk);
    if (fl || (fb && q.size() == 0)) begin
      q.delete();
    end else if (fb) begin
      h = q[0];
      q.delete();
      q.push_back(h);
    end else begin
      if (qok) for (int i = 0; i < pp; i++) void'(q.pop_front());
      if (pok) begin
        if (pc > 0) q.push_back(d0);
        if (pc > 1) q.push_back(d1);
      end
    end
    #1;
    check_state();
  endtask

  task automatic idle();
    @(negedge clk);
    flush = 0; fbf = 0; push_cnt = 0; pop_cnt = 0;
  endtask

  initial begin
    bit o, u;
    int unsigned v;
    tbl[0]  = '{0, 0, 2, 1,  2,  0, 2, 0, 0, 1};
    tbl[1]  = '{0, 0, 2, 3,  4,  0, 4, 0, 0, 1};
    tbl[2]  = '{0, 0, 2, 5,  6,  0, 6, 0, 0, 1};
    tbl[3]  = '{0, 0, 2, 7,  8,  2, 4, 1, 0, 3};
    tbl[4]  = '{0, 0, 0, 0,  0,  1, 3, 0, 0, 4};
    tbl[5]  = '{0, 0, 0, 0,  0,  2, 1, 0, 0, 6};
    tbl[6]  = '{0, 0, 0, 0,  0,  2, 1, 0, 1, 6};
    tbl[7]  = '{0, 0, 2, 7,  8,  1, 2, 0, 0, 7};
    tbl[8]  = '{0, 0, 2, 9,  10, 0, 4, 0, 0, 7};
    tbl[9]  = '{0, 1, 2, 11, 12, 0, 1, 0, 0, 7};
    tbl[10] = '{0, 0, 2, 13, 14, 0, 3, 0, 0, 7};
    tbl[11] = '{1, 1, 2, 15, 16, 1, 0, 0, 0, 0};

    rst_n = 0; flush = 0; fbf = 0; push_cnt = 0; pop_cnt = 0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("rst_data0", data_o[0], 0);
    chk("rst_data1", data_o[1], 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_udf", udf_o, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].fb, tbl[i].pc, tbl[i].d0, tbl[i].d1,
           tbl[i].pp, o, u);
      chk($sformatf("tbl%0d_cnt", i), cnt_o, tbl[i].cnt);
      chk($sformatf("tbl%0d_ovf", i), o, tbl[i].ovf);
      chk($sformatf("tbl%0d_udf", i), u, tbl[i].udf);
      if (tbl[i].cnt > 0)
        chk($sformatf("tbl%0d_head", i), data_o[0], tbl[i].head);
    end

    // Pointer wrap: steady traffic, count oscillates 2..4.
    v = 100;
    step(0, 0, 2, v, v + 1, 0, o, u);
    v += 2;
    for (int i = 0; i < 21; i++) begin
      if (i % 3 == 2) step(0, 0, 0, 0, 0, 2, o, u);
      else begin
        step(0, 0, 2, v, v + 1, 1, o, u);
        v += 2;
      end
      chk("wrap_ovf", o, 0);
    end

    // Reset pulled mid-push with data stored.
    idle();
    push_cnt = 2; data_i[0] = 32'hdead; data_i[1] = 32'hbeef;
    #2;
    rst_n = 0;
    q.delete();
    #1;
    check_state();
    chk("midrst_data0", data_o[0], 0);
    chk("midrst_data1", data_o[1], 0);
    chk("midrst_ovf", ovf_o, 0);
    @(negedge clk);
    push_cnt = 0;
    rst_n = 1;

    // Randomized traffic against the queue reference.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 16) == 0,
           $urandom_range(0, 3), $urandom, $urandom,
           $urandom_range(0, 2), o, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
